// File: rtl/gray_to_binary_sync_decoder.sv
// Gray-coded word synchroniser and Gray-to-binary decoder with change-valid strobe.
// Define GRAY_DECODER_STEP_CHECK_EN to add the single-bit step checker and error counter.
module gray_to_binary_sync_decoder #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  Clock,
   input  logic                  Reset_n,
   input  logic                  Enable_In,
   input  logic [DATA_WIDTH-1:0] Gray_Data_In,
   input  logic                  Clear_Error_In,
   output logic [DATA_WIDTH-1:0] Binary_Data_Out,
   output logic                  Valid_Out,
   output logic                  Step_Error_Out,
   output logic [7:0]            Error_Count_Out
);

   localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

   logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [FILL_W-1:0]     fill_q;
   logic                  primed_q, primed_d;
   logic [DATA_WIDTH-1:0] g_prev_q, g_prev_d;
   logic [DATA_WIDTH-1:0] bin_q, bin_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] g;
   logic                  filled, prime, change, load;

   function automatic logic [DATA_WIDTH-1:0] g2b(input logic [DATA_WIDTH-1:0] gray);
      logic [DATA_WIDTH-1:0] bin;
      bin[DATA_WIDTH-1] = gray[DATA_WIDTH-1];
      for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

   assign g      = sync_q[SYNC_STAGES-1];
   assign filled = (fill_q == FILL_W'(SYNC_STAGES));
   assign prime  = Enable_In && filled && !primed_q;
   assign change = Enable_In && primed_q && (g != g_prev_q);
   assign load   = prime || change;

   // Chain and fill counter run regardless of Enable_In
   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         fill_q <= '0;
      end else begin
         sync_q[0] <= Gray_Data_In;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         if (!filled) begin
            fill_q <= fill_q + FILL_W'(1);
         end
      end
   end

   always_comb begin
      primed_d = primed_q;
      g_prev_d = g_prev_q;
      bin_d    = bin_q;
      valid_d  = 1'b0;
      if (!Enable_In) begin
         primed_d = 1'b0;
      end else if (load) begin
         primed_d = 1'b1;
         g_prev_d = g;
         bin_d    = g2b(g);
         valid_d  = 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         primed_q <= 1'b0;
         g_prev_q <= '0;
         bin_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         primed_q <= primed_d;
         g_prev_q <= g_prev_d;
         bin_q    <= bin_d;
         valid_q  <= valid_d;
      end
   end

   assign Binary_Data_Out = bin_q;
   assign Valid_Out       = valid_q;

`ifdef GRAY_DECODER_STEP_CHECK_EN
   logic [DATA_WIDTH-1:0] diff;
   logic                  multi_bit;
   logic                  err_flag_q, err_flag_d;
   logic [7:0]            err_cnt_q, err_cnt_d;

   // x & (x-1) is non-zero exactly when more than one bit is set
   assign diff      = g ^ g_prev_q;
   assign multi_bit = |(diff & (diff - DATA_WIDTH'(1)));

   always_comb begin
      err_flag_d = err_flag_q;
      err_cnt_d  = err_cnt_q;
      if (change && multi_bit) begin
         err_flag_d = 1'b1;
         if (Clear_Error_In) begin
            err_cnt_d = 8'd1;
         end else if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end else if (Clear_Error_In) begin
         err_flag_d = 1'b0;
         err_cnt_d  = 8'd0;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         err_flag_q <= 1'b0;
         err_cnt_q  <= 8'd0;
      end else begin
         err_flag_q <= err_flag_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign Step_Error_Out  = err_flag_q;
   assign Error_Count_Out = err_cnt_q;
`else
   logic unused_clear;
   assign unused_clear    = Clear_Error_In;
   assign Step_Error_Out  = 1'b0;
   assign Error_Count_Out = 8'd0;
`endif

endmodule

// File: doc/gray_to_binary_sync_decoder.md
# gray_to_binary_sync_decoder

Consumes a Gray-coded word from another clock domain, typically the 32-bit Binary-to-Gray converter output, and returns it to binary in the local `Clock` domain. The word passes through a parameterised synchroniser chain and is then converted Gray→binary into a registered output with a change-valid strobe. Optionally, the block checks that successive samples differ by at most one bit, which flags broken Gray sequencing or metastability corruption.

## Interface
- `DATA_WIDTH`, 32: width of the Gray and binary words (2..32).
- `SYNC_STAGES`, 2: synchroniser depth in flops (2..4).
- `Clock` input 1: sole clock; all state updates on its rising edge.
- `Reset_n` input 1: reset, synchronous, active-low.
- `Enable_In` input 1: decode enable.
- `Gray_Data_In` input DATA_WIDTH: asynchronous Gray word.
- `Clear_Error_In` input 1: clears error flag and error count; single-cycle pulse.
- `Binary_Data_Out` output DATA_WIDTH: decoded binary word, registered.
- `Valid_Out` output 1: one-cycle strobe when `Binary_Data_Out` is loaded with a new value.
- `Step_Error_Out` output 1: sticky flag for an illegal Gray step.
- `Error_Count_Out` output 8: saturating count of illegal steps.

## Operation
- **Synchroniser chain:**
  - `Gray_Data_In` passes through SYNC_STAGES flops, denoted S[1..N].
  - The chain clocks every cycle, independent of `Enable_In`.
  - S[N] is the synchronised sample, G.
- **Fill counter:**
  - Width is clog2(SYNC_STAGES+1).
  - Cleared by reset, then increments every cycle until it saturates at SYNC_STAGES.
  - The chain is "filled" when the counter equals SYNC_STAGES.
- **Reference register:**
  - `Primed` flag plus G_prev (DATA_WIDTH).
  - On the first cycle with `Enable_In`=1, filled=1 and `Primed`=0 (the prime cycle):
    - Load G_prev ← G, `Primed` ← 1.
    - Load `Binary_Data_Out` ← g2b(G) and assert `Valid_Out`=1.
    - No step check.
  - `Enable_In`=0 clears `Primed` and holds `Binary_Data_Out`.
- **Primed cycles** (`Enable_In`=1, `Primed`=1):
  - If G ≠ G_prev: load `Binary_Data_Out` ← g2b(G) and G_prev ← G, and pulse `Valid_Out`.
  - If G == G_prev: hold; `Valid_Out`=0.
- **g2b conversion:**
  - B[W-1] = G[W-1].
  - B[i] = B[i+1] ^ G[i] for i = W-2..0.
  - Evaluated combinationally on G within the same cycle as the load.
- **Step check:**
  - Applies on primed cycles with G ≠ G_prev.
  - If popcount(G ^ G_prev) > 1: set `Step_Error_Out`, and increment `Error_Count_Out`, saturating at 255.
  - The decoded value is still loaded; the error does not block the output.
- **Clear:**
  - `Clear_Error_In`=1 clears the flag and the count.
  - If an error is detected in the same cycle, the error wins: flag=1, count=1.

## Timing
- Reset values:
  - All S[] = 0.
  - `Binary_Data_Out` = 0, `Valid_Out` = 0.
  - `Step_Error_Out` = 0, `Error_Count_Out` = 0.
  - `Primed` = 0, fill counter = 0.
- Latency:
  - `Gray_Data_In` is stable before edge k.
  - G reflects it after edge k+SYNC_STAGES-1.
  - `Binary_Data_Out` and `Valid_Out` update at edge k+SYNC_STAGES.
  - With the default depth this is 2 cycles.
- Earliest prime is the edge after the fill counter saturates. With `Enable_In` held high from reset release, that is the (SYNC_STAGES+1)th edge after reset release.
- Throughput: one decoded value per cycle. Back-to-back changes give consecutive `Valid_Out` pulses.
- `Reset_n` low mid-operation: at the next edge all state returns to reset values, and priming restarts from fill.
- Toggling `Enable_In` low then high forces a fresh prime, so the first value after re-enable is never step-checked.
- Wrap-around: the Gray sequence wrapping from 0x80000000 back to 0x00000000 is a legal single-bit step and raises no error.

## Configuration
- Macro `GRAY_DECODER_STEP_CHECK_EN`.
- Defined: step-check logic, G_prev comparison for errors, sticky flag and counter are present as above.
- Undefined:
  - `Step_Error_Out` is tied 0 and `Error_Count_Out` is tied 0.
  - `Clear_Error_In` is ignored.
  - G_prev is retained for change detection only.
  - Decode and valid behaviour are identical.

## Test plan
1. **Reset and prime.** Apply reset, then release with `Gray_Data_In`=0x00000003 held and `Enable_In`=1.
   - Outputs read 0 until the prime edge.
   - At prime: `Binary_Data_Out`=0x00000002 with a single-cycle `Valid_Out`.
   - No error.
2. **Gray count sweep.** Drive the Gray sequence for binary 0..300, one step per cycle.
   - `Binary_Data_Out` tracks 0..300, delayed SYNC_STAGES cycles.
   - `Valid_Out` is high every cycle.
   - `Step_Error_Out`=0.
3. **Illegal jump.** Primed at Gray 0x00000001, drive 0x00000006.
   - `Binary_Data_Out`=0x00000004.
   - `Step_Error_Out`=1 and `Error_Count_Out`=1, both remaining set.
   - Then pulse `Clear_Error_In`: both return to 0.
4. **Saturation and clear-vs-error priority.**
   - Inject 260 illegal jumps: count holds at 255.
   - Assert `Clear_Error_In` on the same cycle as a new illegal jump: flag=1, count=1.
5. **Enable gating and re-prime.**
   - Drop `Enable_In` for 5 cycles while the input jumps 0x0→0xFF: output holds and there is no `Valid_Out`.
   - Re-enable: prime loads 0x000000AA, the g2b of 0xFF, with no error.
6. **Wrap and mid-run reset.**
   - Gray 0x80000000 → 0x00000000: `Binary_Data_Out` goes 0xFFFFFFFF → 0x00000000 with no error.
   - Assert `Reset_n`=0 for one edge mid-sweep: all outputs 0 next cycle, and re-prime occurs after SYNC_STAGES+1 edges.
